// File: rtl/prof_pkg.sv
// Shared types and address/status constants for cache profiler controllers.
package prof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_SNAP = 2'd2,
        ST_HOLD = 2'd3
    } prof_ctrl_state_t;

    // Register offsets above the last shadow word (absolute address = NUM_CNT + offset)
    localparam int ADDR_ELAPSED = 0;
    localparam int ADDR_WINCNT  = 1;
    localparam int ADDR_STATUS  = 2;

    localparam int STAT_STATE_LSB = 0;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_DONE_BIT  = 3;

endpackage

// File: rtl/prof_window_timer.sv
// Window timer: remaining-cycles down-counter with expiry, and saturating elapsed up-counter.
module prof_window_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] window_i,
    output logic             expire_o,
    output logic [CNT_W-1:0] elapsed_o
);

    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] elapsed_q;
    logic             bounded_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            remaining_q <= '0;
            elapsed_q   <= '0;
            bounded_q   <= 1'b0;
        end else if (load_i) begin
            remaining_q <= window_i;
            elapsed_q   <= '0;
            bounded_q   <= (window_i != '0);
        end else if (run_i) begin
            // An unbounded window never decrements, so it can never wrap into an expiry
            if (bounded_q) begin
                remaining_q <= remaining_q - CNT_W'(1);
            end
            if (elapsed_q != '1) begin
                elapsed_q <= elapsed_q + CNT_W'(1);
            end
        end
    end

    assign expire_o  = bounded_q && (remaining_q == CNT_W'(1));
    assign elapsed_o = elapsed_q;

endmodule

// File: rtl/cache_profiler_ctrl.sv
// Cache profiler window sequencer: FSM, shadow snapshot bank and host read port.
module cache_profiler_ctrl
    import prof_pkg::*;
#(
    parameter int NUM_CNT = 8,
    parameter int CNT_W   = 32,
    parameter int ADDR_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic                     cmd_clear,
    input  logic [CNT_W-1:0]         window_cycles,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic                     prof_enable,
    input  logic                     rd_req,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_valid,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     busy,
    output logic                     done
);

    localparam logic [ADDR_W-1:0] A_ELAPSED = ADDR_W'(NUM_CNT + ADDR_ELAPSED);
    localparam logic [ADDR_W-1:0] A_WINCNT  = ADDR_W'(NUM_CNT + ADDR_WINCNT);
    localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(NUM_CNT + ADDR_STATUS);

    prof_ctrl_state_t state_q, state_d;
    logic             prof_enable_q;
    logic             busy_q;
    logic             done_q;

    logic             tmr_load;
    logic             tmr_run;
    logic             tmr_expire;
    logic [CNT_W-1:0] elapsed;

    logic [CNT_W-1:0] shadow_q [NUM_CNT];
    logic [CNT_W-1:0] win_count_q;
    logic             rd_valid_q;
    logic [CNT_W-1:0] rd_data_q;
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] status;

    assign tmr_load = !cmd_clear && cmd_start &&
                      ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign tmr_run  = (state_q == ST_RUN);

    prof_window_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .run_i     (tmr_run),
        .clear_i   (cmd_clear),
        .window_i  (window_cycles),
        .expire_o  (tmr_expire),
        .elapsed_o (elapsed)
    );

    // Clear outranks stop, stop outranks start; start is only honoured from IDLE/HOLD
    always_comb begin
        state_d = state_q;
        if (cmd_clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (cmd_start) state_d = ST_RUN;
                ST_RUN:  if (cmd_stop || tmr_expire) state_d = ST_SNAP;
                ST_SNAP: state_d = ST_HOLD;
                ST_HOLD: if (cmd_start) state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            prof_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            prof_enable_q <= (state_d == ST_RUN) || (state_d == ST_SNAP);
            busy_q        <= (state_d == ST_RUN) || (state_d == ST_SNAP);
            done_q        <= (state_d == ST_HOLD);
        end
    end

    // A clear landing on the SNAP cycle wins: no capture and no window count
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
            win_count_q <= '0;
        end else if (cmd_clear) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= '0;
        end else if (state_q == ST_SNAP) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_q[i] <= cnt_in[i*CNT_W +: CNT_W];
            win_count_q <= win_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        status = '0;
        status[STAT_STATE_LSB +: 2] = state_q;
        status[STAT_BUSY_BIT]       = busy_q;
        status[STAT_DONE_BIT]       = done_q;
    end

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_mux = shadow_q[i];
        end
        if (rd_addr == A_ELAPSED) rd_mux = elapsed;
        if (rd_addr == A_WINCNT)  rd_mux = win_count_q;
        if (rd_addr == A_STATUS)  rd_mux = status;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) rd_data_q <= rd_mux;
        end
    end

    assign prof_enable = prof_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_cache_profiler_ctrl.sv
// Directed test for cache_profiler_ctrl with hand-computed expectations.
module tb_cache_profiler_ctrl;

    localparam int NUM_CNT = 8;
    localparam int CNT_W   = 32;
    localparam int ADDR_W  = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     cmd_start, cmd_stop, cmd_clear;
    logic [CNT_W-1:0]         window_cycles;
    logic [NUM_CNT*CNT_W-1:0] cnt_in;
    logic                     prof_enable;
    logic                     rd_req;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     rd_valid;
    logic [CNT_W-1:0]         rd_data;
    logic                     busy, done;

    int errors = 0;
    int checks = 0;
    logic [31:0] ramp;

    cache_profiler_ctrl #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_start     (cmd_start),
        .cmd_stop      (cmd_stop),
        .cmd_clear     (cmd_clear),
        .window_cycles (window_cycles),
        .cnt_in        (cnt_in),
        .prof_enable   (prof_enable),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Counter word i carries ramp + (i << 16)
    task automatic drive_cnt();
        for (int i = 0; i < NUM_CNT; i++) cnt_in[i*CNT_W +: CNT_W] = ramp + (32'(i) << 16);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ramp = ramp + 1;
        drive_cnt();
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [ADDR_W-1:0] addr, input logic [31:0] exp, input string tag);
        rd_addr = addr;
        rd_req  = 1'b1;
        step();
        rd_req  = 1'b0;
        chk(32'(rd_valid), 32'd1, {tag, "_valid"});
        chk(rd_data, exp, tag);
    endtask

    initial begin
        int pen;
        int done_at;
        logic [31:0] r0;

        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
        window_cycles = '0; rd_req = 1'b0; rd_addr = '0; ramp = 0;
        drive_cnt();
        step(); step();
        rst = 1'b0;
        chk(32'(prof_enable), 0, "rst_pen");
        chk(32'(busy), 0, "rst_busy");
        chk(32'(done), 0, "rst_done");
        chk(32'(rd_valid), 0, "rst_rd_valid");
        chk(rd_data, 0, "rst_rd_data");

        // Bounded window of 10: SNAP cycle carries ramp 11
        ramp = 0; drive_cnt();
        window_cycles = 10; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        pen = 0; done_at = -1;
        for (int i = 0; i < 14; i++) begin
            if (prof_enable) pen++;
            if (done && done_at < 0) done_at = i;
            step();
        end
        chk(32'(pen), 11, "t1_pen_cycles");
        chk(32'(done_at), 11, "t1_done_rise");
        rd(4'd0, 32'd11, "t1_shadow0");
        rd(4'd8, 32'd10, "t1_elapsed");
        rd(4'd9, 32'd1, "t1_wincnt");
        rd(4'd10, 32'hB, "t1_status");

        // Back-to-back reads
        rd_req = 1'b1; rd_addr = 4'd0;
        step();
        chk(32'(rd_valid), 1, "rt_v0"); chk(rd_data, 32'd11, "rt_d0");
        rd_addr = 4'd1;
        step();
        chk(32'(rd_valid), 1, "rt_v1"); chk(rd_data, 32'h0001_000B, "rt_d1");
        rd_addr = 4'd15;
        step();
        chk(32'(rd_valid), 1, "rt_v15"); chk(rd_data, 32'd0, "rt_d15");
        rd_req = 1'b0;
        step();
        chk(32'(rd_valid), 0, "rt_v_idle");

        // Re-arm from HOLD with a 3-cycle window
        r0 = ramp;
        window_cycles = 3; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        pen = 0;
        for (int i = 0; i < 8; i++) begin
            if (prof_enable) pen++;
            if (i == 0) begin rd_addr = 4'd0; rd_req = 1'b1; end
            if (i == 1) begin
                rd_req = 1'b0;
                chk(32'(rd_valid), 1, "t4_old_valid");
                chk(rd_data, 32'd11, "t4_old_shadow0");
            end
            step();
        end
        chk(32'(pen), 4, "t4_pen_cycles");
        chk(32'(done), 1, "t4_done");
        rd(4'd0, r0 + 32'd4, "t4_shadow0");
        rd(4'd8, 32'd3, "t4_elapsed");
        rd(4'd9, 32'd2, "t4_wincnt");

        // Unbounded window closed by stop after 5 RUN cycles
        r0 = ramp;
        window_cycles = 0; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        step(); step(); step(); step();
        chk(32'(busy), 1, "t2_still_run");
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        chk(32'(busy), 1, "t2_snap_busy");
        chk(32'(prof_enable), 1, "t2_snap_pen");
        chk(32'(done), 0, "t2_snap_done");
        step();
        chk(32'(done), 1, "t2_hold_done");
        chk(32'(prof_enable), 0, "t2_hold_pen");
        rd(4'd8, 32'd5, "t2_elapsed");
        rd(4'd10, 32'hB, "t2_status");
        rd(4'd9, 32'd3, "t2_wincnt");
        rd(4'd0, r0 + 32'd6, "t2_shadow0");
        cmd_stop = 1'b1;
        step();
        cmd_stop = 1'b0;
        chk(32'(done), 1, "t2_stop_in_hold");

        // Clear + stop + start together in RUN
        window_cycles = 0; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        step();
        cmd_clear = 1'b1; cmd_stop = 1'b1; cmd_start = 1'b1;
        step();
        cmd_clear = 1'b0; cmd_stop = 1'b0; cmd_start = 1'b0;
        chk(32'(prof_enable), 0, "t3_pen");
        chk(32'(busy), 0, "t3_busy");
        chk(32'(done), 0, "t3_done");
        rd(4'd10, 32'h0, "t3_status");
        rd(4'd0, 32'd0, "t3_shadow0");
        rd(4'd1, 32'd0, "t3_shadow1");
        rd(4'd8, 32'd0, "t3_elapsed");
        rd(4'd9, 32'd3, "t3_wincnt");

        // Reset in the middle of a window, after a fresh snapshot
        window_cycles = 2; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        for (int i = 0; i < 10 && !done; i++) step();
        chk(32'(done), 1, "t6_pre_done");
        window_cycles = 10; cmd_start = 1'b1;
        step();
        cmd_start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk(32'(prof_enable), 0, "t6_pen");
        chk(32'(busy), 0, "t6_busy");
        rd(4'd0, 32'd0, "t6_shadow0");
        rd(4'd8, 32'd0, "t6_elapsed");
        rd(4'd9, 32'd0, "t6_wincnt");
        rd(4'd10, 32'd0, "t6_status");
        chk(32'(done), 0, "t6_no_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_profiler_ctrl.md
Name: cache_profiler_ctrl

Overview:
Sequences the cache profiler through measurement windows. It drives the profiler enable, bounds each window by a programmable cycle count or a stop command, and snapshots all profiler counters into shadow registers when the window closes. Software or the debug host reads the shadows through a simple request/valid read port. Sits between the host register interface and the cache profiler instance.

Parameters:
NUM_CNT, 8, number of profiler counter inputs captured per window
CNT_W, 32, width of each counter, window length and elapsed-cycle register
ADDR_W, 4, read-address width; must satisfy 2**ADDR_W >= NUM_CNT+3

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
cmd_start  in  1  single-cycle pulse: open a window
cmd_stop  in  1  single-cycle pulse: close the current window early
cmd_clear  in  1  single-cycle pulse: abort, clear shadows, return to IDLE
window_cycles  in  CNT_W  window length in cycles; 0 = unbounded (stop-only); sampled at start
cnt_in  in  NUM_CNT*CNT_W  profiler counters, packed; counter i at bits [i*CNT_W +: CNT_W]
prof_enable  out  1  drives profiler enable; low holds the profiler counters cleared
rd_req  in  1  read request, one cycle
rd_addr  in  ADDR_W  read address
rd_valid  out  1  read data valid
rd_data  out  CNT_W  read data
busy  out  1  high in RUN and SNAP
done  out  1  high in HOLD (a snapshot is available)

Behaviour:
- Reset (rst=1 at a clk edge) puts the block in IDLE and zeroes the shadows, elapsed, win_count, rd_valid and rd_data. prof_enable, busy and done are 0.
- Reset mid-window aborts immediately, with no snapshot.
- States: IDLE, RUN, SNAP, HOLD (2-bit encoding).
- Per-state behaviour and transitions:
  - IDLE: prof_enable=0. cmd_start -> RUN.
  - RUN: prof_enable=1. remaining counts down and elapsed counts up, saturating at all-ones.
    - Entry: remaining is loaded from window_cycles and elapsed is set to 0.
    - RUN -> SNAP on cmd_stop, or when window_cycles!=0 and remaining==1 in this cycle.
    - A window_cycles=N window therefore keeps prof_enable high for exactly N cycles in RUN, plus the SNAP cycle.
  - SNAP: one cycle. prof_enable stays 1. All cnt_in words are captured into the shadows and win_count increments (wraps). Always goes to HOLD.
  - HOLD: prof_enable=0 and done=1. Shadows are held. cmd_start -> RUN, which starts a new window; the profiler was cleared during HOLD.
- Command priority within one cycle: cmd_clear > cmd_stop > cmd_start.
  - cmd_clear in any state -> IDLE, zeroes the shadows and elapsed, keeps win_count.
  - cmd_start in RUN or SNAP is ignored.
  - cmd_stop outside RUN is ignored.
  - cmd_stop and a natural expiry in the same cycle give a single snapshot.
- Shadows change only in SNAP and on clear/reset. The profiler counters lag events by one cycle; the snapshot reflects events up to and including the cycle before SNAP.
- Read port:
  - rd_req is accepted in every state, with no back-pressure.
  - rd_valid is asserted exactly one cycle after rd_req, with rd_data registered. Back-to-back reads give back-to-back valid.
  - Address map:
    - 0..NUM_CNT-1: shadow i.
    - NUM_CNT: elapsed. While in RUN this is the live value.
    - NUM_CNT+1: win_count.
    - NUM_CNT+2: status = {zero-pad, done, busy, state[1:0]}.
    - Other addresses read 0.
  - A read in the same cycle as SNAP returns the pre-snapshot shadow value.

Decomposition:
- Shared package prof_pkg holds the following, reused by future profiler controllers:
  - typedef prof_ctrl_state_t (IDLE, RUN, SNAP, HOLD);
  - localparam address offsets (ADDR_ELAPSED, ADDR_WINCNT, ADDR_STATUS);
  - the status bit positions.
- One natural sub-module, prof_window_timer, owns:
  - the remaining down-counter with load and expire;
  - the saturating elapsed up-counter.
- The FSM, shadow bank and read mux stay in the top module.

Test Plan:
- Bounded window. Reset, window_cycles=10, pulse cmd_start; cnt_in[0] ramps +1 per cycle from 0.
  - Expect prof_enable high for 11 cycles and done rising the cycle after SNAP.
  - Reading address 0 returns the value cnt_in[0] carried in the SNAP cycle.
  - elapsed=10, win_count=1.
- Early stop. window_cycles=0, cmd_start, cmd_stop 5 cycles later.
  - Expect a SNAP cycle, then HOLD with elapsed=5.
  - The status read returns done=1, busy=0, state=HOLD.
- Simultaneous commands. In RUN, pulse cmd_clear+cmd_stop+cmd_start together.
  - Expect IDLE next cycle, shadows read 0, win_count unchanged.
- Re-arm from HOLD. After test 1, cmd_start with window_cycles=3.
  - Expect a new window of 3 cycles and win_count=2.
  - Shadows hold the old values until the new SNAP.
- Read timing. Issue rd_req on addresses 0, 1, 15 in consecutive cycles.
  - Expect rd_valid on the 3 following cycles with data shadow0, shadow1, 0.
- Reset mid-window. Assert rst during RUN.
  - Expect prof_enable=0 next cycle, all reads 0, win_count=0, and no done pulse.
